// File: rtl/if_fetch_seq.sv
// Instruction-fetch sequencer: one outstanding imem request at a time, feeding a
// 2-entry {pc, instr} buffer toward decode; redirects flush the buffer and kill the in-flight word.
module if_fetch_seq #(
   parameter int PC_STEP = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_q,
   output logic [31:0] pc_next,
   output logic        pc_ena,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   input  logic        id_ready
);

   localparam logic [31:0] STEP = 32'(PC_STEP);

   typedef enum logic {S_REQ = 1'b0, S_WAIT = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [1:0]  cnt;
   logic        drop;
   logic [31:0] tag;
   logic [31:0] e0_pc, e0_instr, e1_pc, e1_instr;
   logic        grant, resp, push, pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_REQ;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == S_REQ) begin
         if (grant) state_nxt = S_WAIT;
      end else begin
         if (imem_rvalid) state_nxt = S_REQ;
      end
   end

   // Request/PC-load outputs are combinational; rst gates them so reset shows idle outputs
   always_comb begin
      imem_req  = rst && (state == S_REQ) && (cnt < 2'd2) && !redirect_valid;
      imem_addr = pc_q;
      grant     = imem_req && imem_gnt;
      pc_ena    = rst && (redirect_valid || grant);
      pc_next   = 32'd0;
      if (rst && redirect_valid) pc_next = redirect_pc;
      else if (grant)            pc_next = pc_q + STEP;
   end

   assign resp = (state == S_WAIT) && imem_rvalid;
   assign push = resp && !drop && !redirect_valid;
   assign pop  = id_valid && id_ready && !redirect_valid;

   // A redirect while a word is owed (or arriving now) marks that one word as dead
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop <= 1'b0;
         tag  <= 32'd0;
      end else if (grant) begin
         drop <= 1'b0;
         tag  <= pc_q;
      end else if (redirect_valid && ((state == S_WAIT) || imem_rvalid)) begin
         drop <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= 2'd0;
         e0_pc    <= 32'd0;
         e0_instr <= 32'd0;
         e1_pc    <= 32'd0;
         e1_instr <= 32'd0;
      end else if (redirect_valid) begin
         cnt <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (cnt == 2'd0) begin
                  e0_pc    <= tag;
                  e0_instr <= imem_rdata;
               end else begin
                  e1_pc    <= tag;
                  e1_instr <= imem_rdata;
               end
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               e0_pc    <= e1_pc;
               e0_instr <= e1_instr;
               cnt      <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  e0_pc    <= tag;
                  e0_instr <= imem_rdata;
               end else begin
                  e0_pc    <= e1_pc;
                  e0_instr <= e1_instr;
                  e1_pc    <= tag;
                  e1_instr <= imem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign id_valid = (cnt != 2'd0);
   assign id_instr = e0_instr;
   assign id_pc    = e0_pc;

endmodule

// File: tb/tb_if_fetch_seq.sv
// Bench for if_fetch_seq: directed scenarios plus a randomized run against a fetch-level model.
module tb_if_fetch_seq;

   localparam int PC_STEP = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_q;
   logic [31:0] pc_next;
   logic        pc_ena;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        id_ready;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   always #5 clk = ~clk;

   if_fetch_seq #(.PC_STEP(PC_STEP)) dut (
      .clk(clk), .rst(rst), .pc_q(pc_q), .pc_next(pc_next), .pc_ena(pc_ena),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
   );

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   task automatic test_reset();
      rst = 1'b0; pc_q = 32'h0040_0000; redirect_valid = 1'b1; redirect_pc = 32'h1234_5678;
      imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF; id_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
      n_tests++; if (pc_ena !== 1'b0) begin n_fail++; $display("FAIL reset_pc_ena: got %b want 0", pc_ena); end
      n_tests++; if (pc_next !== 32'd0) begin n_fail++; $display("FAIL reset_pc_next: got %h want 0", pc_next); end
      n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
      n_tests++; if (id_instr !== 32'd0) begin n_fail++; $display("FAIL reset_id_instr: got %h want 0", id_instr); end
      n_tests++; if (id_pc !== 32'd0) begin n_fail++; $display("FAIL reset_id_pc: got %h want 0", id_pc); end
      redirect_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
   endtask

   task automatic test_seq_fetch();
      @(posedge clk); #1;
      rst = 1'b1; pc_q = 32'h0040_0000; imem_gnt = 1'b1; id_ready = 1'b0;
      @(negedge clk);
      n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_req: got %b want 1", imem_req); end
      n_tests++; if (imem_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL seq_addr: got %h want 00400000", imem_addr); end
      n_tests++; if (pc_ena !== 1'b1) begin n_fail++; $display("FAIL seq_pc_ena: got %b want 1", pc_ena); end
      n_tests++; if (pc_next !== 32'h0040_0004) begin n_fail++; $display("FAIL seq_pc_next: got %h want 00400004", pc_next); end
      @(posedge clk); #1;
      pc_q = 32'h0040_0004; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_wait_req: got %b want 0", imem_req); end
      n_tests++; if (pc_ena !== 1'b0) begin n_fail++; $display("FAIL seq_wait_pc_ena: got %b want 0", pc_ena); end
      n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL seq_wait_valid: got %b want 0", id_valid); end
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      @(negedge clk);
      n_tests++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL seq_id_valid: got %b want 1", id_valid); end
      n_tests++; if (id_pc !== 32'h0040_0000) begin n_fail++; $display("FAIL seq_id_pc: got %h want 00400000", id_pc); end
      n_tests++; if (id_instr !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL seq_id_instr: got %h want deadbeef", id_instr); end
      n_tests++; if (imem_addr !== 32'h0040_0004 || imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_req2: got req=%b addr=%h want req=1 addr=00400004", imem_req, imem_addr); end
      n_tests++; if (pc_next !== 32'h0040_0008) begin n_fail++; $display("FAIL seq_pc_next2: got %h want 00400008", pc_next); end
      @(posedge clk); #1;
      pc_q = 32'h0040_0008;
   endtask

   task automatic test_backpressure();
      imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_full_req[%0d]: got %b want 0", i, imem_req); end
         n_tests++; if (id_pc !== 32'h0040_0000) begin n_fail++; $display("FAIL bp_full_head[%0d]: got %h want 00400000", i, id_pc); end
         @(posedge clk); #1;
      end
      id_ready = 1'b1;
      @(negedge clk);
      n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_pop_req: got %b want 0", imem_req); end
      @(posedge clk); #1;
      id_ready = 1'b0;
      @(negedge clk);
      n_tests++; if (id_pc !== 32'h0040_0004 || id_instr !== 32'h1111_1111) begin n_fail++; $display("FAIL bp_head2: got %h/%h want 00400004/11111111", id_pc, id_instr); end
      n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL bp_new_req: got %b want 1", imem_req); end
      n_tests++; if (pc_next !== 32'h0040_000C) begin n_fail++; $display("FAIL bp_pc_next: got %h want 0040000c", pc_next); end
      @(posedge clk); #1;
      pc_q = 32'h0040_000C; imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
      @(negedge clk);
      n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_wait_req: got %b want 0", imem_req); end
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      @(negedge clk);
      n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_refull_req: got %b want 0", imem_req); end
      imem_gnt = 1'b0; id_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++; if (id_pc !== 32'h0040_0008 || id_instr !== 32'h2222_2222) begin n_fail++; $display("FAIL bp_head3: got %h/%h want 00400008/22222222", id_pc, id_instr); end
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", id_valid); end
   endtask

   task automatic test_redirect_wait();
      @(posedge clk); #1;
      pc_q = 32'h0040_0008; imem_gnt = 1'b1; id_ready = 1'b1;
      @(negedge clk);
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0008) begin n_fail++; $display("FAIL rw_req: got req=%b addr=%h want 1/00400008", imem_req, imem_addr); end
      @(posedge clk); #1;
      imem_gnt = 1'b0; pc_q = 32'h0040_000C; redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
      @(negedge clk);
      n_tests++; if (pc_ena !== 1'b1 || pc_next !== 32'h0040_0100) begin n_fail++; $display("FAIL rw_redirect_pc: got ena=%b next=%h want 1/00400100", pc_ena, pc_next); end
      n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_redirect_req: got %b want 0", imem_req); end
      @(posedge clk); #1;
      redirect_valid = 1'b0; pc_q = 32'h0040_0100; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0008;
      @(negedge clk);
      n_tests++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL rw_stale_cycle: got req=%b valid=%b want 0/0", imem_req, id_valid); end
      @(posedge clk); #1;
      imem_rvalid = 1'b0; imem_gnt = 1'b1;
      @(negedge clk);
      n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rw_dropped: got valid=%b pc=%h want valid 0", id_valid, id_pc); end
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin n_fail++; $display("FAIL rw_target_req: got req=%b addr=%h want 1/00400100", imem_req, imem_addr); end
      @(posedge clk); #1;
      imem_gnt = 1'b0; pc_q = 32'h0040_0104; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0100;
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      @(negedge clk);
      n_tests++; if (id_valid !== 1'b1 || id_pc !== 32'h0040_0100 || id_instr !== 32'h0000_0100) begin n_fail++; $display("FAIL rw_target_head: got %b/%h/%h want 1/00400100/00000100", id_valid, id_pc, id_instr); end
   endtask

   task automatic test_redirect_same_cycle();
      @(posedge clk); #1;
      imem_gnt = 1'b1; id_ready = 1'b1;
      @(posedge clk); #1;
      imem_gnt = 1'b0; pc_q = 32'h0040_0108; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0104;
      redirect_valid = 1'b1; redirect_pc = 32'h0040_0200;
      @(negedge clk);
      n_tests++; if (pc_ena !== 1'b1 || pc_next !== 32'h0040_0200) begin n_fail++; $display("FAIL rs_pc: got ena=%b next=%h want 1/00400200", pc_ena, pc_next); end
      n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rs_req: got %b want 0", imem_req); end
      @(posedge clk); #1;
      redirect_valid = 1'b0; imem_rvalid = 1'b0; pc_q = 32'h0040_0200;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rs_dropped[%0d]: got valid=%b pc=%h want 0", i, id_valid, id_pc); end
         n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0200) begin n_fail++; $display("FAIL rs_next_req[%0d]: got %b/%h want 1/00400200", i, imem_req, imem_addr); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_async_reset();
      pc_q = 32'h0040_0300; imem_gnt = 1'b1; id_ready = 1'b0;
      @(posedge clk); #1;
      imem_gnt = 1'b0; pc_q = 32'h0040_0304; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
      @(posedge clk); #1;
      imem_rvalid = 1'b0; imem_gnt = 1'b1;
      @(posedge clk); #1;
      imem_gnt = 1'b0; pc_q = 32'h0040_0308;
      @(negedge clk);
      n_tests++; if (id_valid !== 1'b1 || id_pc !== 32'h0040_0300) begin n_fail++; $display("FAIL ar_pre: got %b/%h want 1/00400300", id_valid, id_pc); end
      #2 rst = 1'b0;
      #1;
      n_tests++; if (id_valid !== 1'b0 || id_pc !== 32'd0 || id_instr !== 32'd0) begin n_fail++; $display("FAIL ar_id: got %b/%h/%h want 0/0/0", id_valid, id_pc, id_instr); end
      n_tests++; if (imem_req !== 1'b0 || pc_ena !== 1'b0 || pc_next !== 32'd0) begin n_fail++; $display("FAIL ar_ctrl: got req=%b ena=%b next=%h want 0/0/0", imem_req, pc_ena, pc_next); end
      @(posedge clk); #1;
      rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0304;
      @(negedge clk);
      n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL ar_req_state: got %b want 1", imem_req); end
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      @(negedge clk);
      n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL ar_stale_push: got valid=%b instr=%h want 0", id_valid, id_instr); end
   endtask

   task automatic test_wrap();
      @(posedge clk); #1;
      pc_q = 32'hFFFF_FFFC; imem_gnt = 1'b1; id_ready = 1'b0;
      @(negedge clk);
      n_tests++; if (pc_ena !== 1'b1 || pc_next !== 32'd0) begin n_fail++; $display("FAIL wrap_pc: got ena=%b next=%h want 1/00000000", pc_ena, pc_next); end
      n_tests++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
      @(posedge clk); #1;
      imem_gnt = 1'b0; pc_q = 32'd0; imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444;
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      @(negedge clk);
      n_tests++; if (id_pc !== 32'hFFFF_FFFC || id_instr !== 32'h4444_4444) begin n_fail++; $display("FAIL wrap_head: got %h/%h want fffffffc/44444444", id_pc, id_instr); end
   endtask

   // Model works per fetch: an outstanding fetch is either live or killed by a redirect.
   task automatic test_random();
      ent_t        q[$];
      bit          out_live   = 1'b0;
      bit          out_killed = 1'b0;
      logic [31:0] out_pc     = 32'd0;
      bit          mem_busy   = 1'b0;
      int          mem_lat    = 0;
      logic [31:0] mem_addr   = 32'd0;
      logic [31:0] pc_reg;
      bit          exp_req, grant, resp, exp_ena;
      logic [31:0] exp_next;
      @(posedge clk); #1;
      rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      pc_reg = $urandom & 32'hFFFF_FFFC;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         pc_q = pc_reg;
         if (mem_busy) mem_lat--;
         if (mem_busy && mem_lat == 0) begin
            imem_rvalid = 1'b1; imem_rdata = instr_of(mem_addr);
         end else if (!mem_busy && $urandom_range(7) == 0) begin
            imem_rvalid = 1'b1; imem_rdata = $urandom;
         end else begin
            imem_rvalid = 1'b0; imem_rdata = $urandom;
         end
         imem_gnt       = ($urandom_range(2) != 0);
         redirect_valid = ($urandom_range(9) == 0);
         redirect_pc    = $urandom & 32'hFFFF_FFFC;
         id_ready       = ($urandom_range(1) == 1);
         @(negedge clk);
         exp_req  = !out_live && (q.size() < 2) && !redirect_valid;
         grant    = exp_req && imem_gnt;
         exp_ena  = redirect_valid || grant;
         exp_next = redirect_valid ? redirect_pc : pc_q + PC_STEP;
         n_tests++; if (imem_req !== exp_req) begin n_fail++; $display("FAIL rnd_req@%0d: got %b want %b", cyc, imem_req, exp_req); end
         n_tests++; if (pc_ena !== exp_ena) begin n_fail++; $display("FAIL rnd_pc_ena@%0d: got %b want %b", cyc, pc_ena, exp_ena); end
         if (exp_ena) begin
            n_tests++; if (pc_next !== exp_next) begin n_fail++; $display("FAIL rnd_pc_next@%0d: got %h want %h", cyc, pc_next, exp_next); end
         end
         if (exp_req) begin
            n_tests++; if (imem_addr !== pc_q) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, imem_addr, pc_q); end
         end
         n_tests++; if (id_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, id_valid, q.size() != 0); end
         if (q.size() != 0) begin
            n_tests++; if (id_pc !== q[0].pc || id_instr !== q[0].instr) begin n_fail++; $display("FAIL rnd_head@%0d: got %h/%h want %h/%h", cyc, id_pc, id_instr, q[0].pc, q[0].instr); end
         end
         resp = out_live && imem_rvalid;
         if (redirect_valid) begin
            q.delete();
            if (out_live) out_killed = 1'b1;
         end else begin
            if (q.size() != 0 && id_ready) void'(q.pop_front());
            if (resp && !out_killed) q.push_back('{out_pc, imem_rdata});
         end
         if (resp) out_live = 1'b0;
         if (grant) begin
            out_live = 1'b1; out_killed = 1'b0; out_pc = pc_q;
         end
         if (exp_ena) pc_reg = exp_next;
         if (imem_rvalid && mem_busy) mem_busy = 1'b0;
         if (grant) begin
            mem_busy = 1'b1; mem_lat = $urandom_range(3, 1); mem_addr = pc_q;
         end
         @(posedge clk); #1;
      end
      imem_rvalid = 1'b0; redirect_valid = 1'b0; imem_gnt = 1'b0;
   endtask

   initial begin
      rst = 1'b0; pc_q = 32'd0; redirect_valid = 1'b0; redirect_pc = 32'd0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0; id_ready = 1'b0;
      test_reset();
      test_seq_fetch();
      test_backpressure();
      test_redirect_wait();
      test_redirect_same_cycle();
      test_async_reset();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/if_fetch_seq.md
# if_fetch_seq

Instruction-fetch sequencer. It sits between the PC register and the decode stage. It reads the current PC and issues one instruction-memory request at a time. For each granted request it drives the PC register's next value and enable. Returned instructions go into a 2-entry {pc, instr} buffer, which presents them to decode under a valid/ready handshake. Redirects from branch or jump resolution flush the buffer and discard any in-flight response.

## Interface
- `PC_STEP`, default 4: byte increment applied to the PC on each granted fetch.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset asserted).
- `pc_q`  in  32  current PC, taken from the PC register output.
- `pc_next`  out  32  value to load into the PC register.
- `pc_ena`  out  1  PC register load enable; high for exactly one cycle per load.
- `redirect_valid`  in  1  branch or jump taken; one-cycle pulse.
- `redirect_pc`  in  32  redirect target, sampled when `redirect_valid` = 1.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; equals `pc_q` whenever `imem_req` = 1.
- `imem_gnt`  in  1  memory accepted the request this cycle.
- `imem_rvalid`  in  1  response data valid; arrives 1 or more cycles after the grant.
- `imem_rdata`  in  32  instruction word.
- `id_valid`  out  1  buffer head is valid.
- `id_instr`  out  32  head instruction.
- `id_pc`  out  32  PC of the head instruction.
- `id_ready`  in  1  decode accepts the head this cycle.

## Operation
- **States:**
  - `REQ`: may request memory.
  - `WAIT`: one request outstanding; `imem_req` = 0.
- **Request rule.** `imem_req` = 1 when all of the following hold:
  - state is `REQ`;
  - buffer count < 2 (this count includes the pending push);
  - `redirect_valid` = 0.
- **Grant** (`imem_req` and `imem_gnt` in the same cycle):
  - `pc_ena` = 1 and `pc_next` = `pc_q` + `PC_STEP`, with the sum taken mod 2^32.
  - The tag register latches `pc_q`.
  - The state moves to `WAIT`, and the drop flag is cleared.
- **Response** (`imem_rvalid` in `WAIT`):
  - If the drop flag = 0, push {tag, `imem_rdata`} into the buffer.
  - If the drop flag = 1, discard the word.
  - In both cases the state returns to `REQ`.
- **`imem_rvalid` outside `WAIT`:** ignored.
- **Buffer:** 2 entries, FIFO order.
  - Pop when `id_valid` and `id_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - The request rule guarantees a push never meets a full buffer. Overflow is impossible, so it needs no handling.
- **Redirect** (`redirect_valid` = 1):
  - `pc_ena` = 1 and `pc_next` = `redirect_pc`. Redirect has priority over the grant increment; a grant cannot coincide with a redirect because `imem_req` is forced to 0.
  - Buffer count goes to 0 and `id_valid` = 0 from the next cycle. A pop in the same cycle is superseded.
  - If the state is `WAIT`, or `imem_rvalid` arrives in the same cycle, set the drop flag so that response is discarded.
  - Two redirects while one response is outstanding still discard exactly one response.
- **Reset** (any time, including mid-request):
  - state = `REQ`, buffer count = 0, drop flag = 0, tag = 0;
  - `id_valid` = 0, `id_instr` = 0, `id_pc` = 0;
  - `pc_ena` = 0, `pc_next` = 0, `imem_req` = 0.
  - A response for a request issued before reset must not be pushed after reset.

## Timing
- `imem_req`, `imem_addr`, `pc_ena` and `pc_next` are combinational from the state, count, `pc_q` and redirect inputs.
- Everything else is registered.
- **Grant at cycle N:** the PC register loads at the N edge, so `pc_q` updates at N+1. The next request can be no earlier than the cycle after the response.
- **Response at cycle M:** the instruction is visible as `id_valid` / `id_instr` from M+1.
- **Best-case throughput:** one instruction every 2 cycles (grant, then response in the next cycle, with the next request in the cycle after).
- **Redirect at cycle R:** the first request to `redirect_pc` is at R+1 if state is `REQ`, otherwise the cycle after the discarded response.

## Test plan
1. **Reset then sequential fetch.** Release `rst` with `pc_q` = 0x00400000; memory grants immediately and responds 1 cycle later.
   - Required: `imem_addr` = 0x00400000, `pc_next` = 0x00400004 with `pc_ena` pulsing;
   - `id_pc` = 0x00400000 and `id_instr` = the word returned, one cycle after the response.
2. **Backpressure.** Hold `id_ready` = 0.
   - Required: after 2 pushes `imem_req` stays 0, with no overflow.
   - Raise `id_ready` for 1 cycle: one pop, then exactly one new request.
3. **Redirect during `WAIT`.** Grant at 0x00400008, pulse `redirect_valid` with `redirect_pc` = 0x00400100 before the response.
   - Required: the response is dropped and the buffer is empty.
   - The next `imem_addr` = 0x00400100, and `id_pc` never shows 0x00400008.
4. **Redirect and response in the same cycle.** The response is discarded; `pc_next` = target and `pc_ena` = 1 in that cycle.
5. **Async reset mid-`WAIT`.** Assert `rst` = 0 between grant and response, deassert, then deliver the stale `imem_rvalid`.
   - Required: outputs at reset values immediately, with no push.
6. **Wrap-around.** `pc_q` = 0xFFFFFFFC granted → `pc_next` = 0x00000000.
